// File: rtl/forward_mux_skid_if.sv
// forward_mux_skid_if: operand handshake bundle for forward_mux_skid.
//   Upstream side : Selector_i, Mux_Data_i, Valid_i -> ; <- Ready_o
//   Downstream    : <- Mux_Output_o, Valid_o, Occupancy_o, Sel_Error_o ; Ready_i ->
// modport slave  : seen by the mux/skid block itself.
// modport master : seen by whatever drives and consumes the block.
interface forward_mux_skid_if #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = $clog2(NInputs)
);
    logic [SelBits-1:0]       Selector_i;
    logic [NInputs*NBits-1:0] Mux_Data_i;
    logic                     Valid_i;
    logic                     Ready_o;
    logic [NBits-1:0]         Mux_Output_o;
    logic                     Valid_o;
    logic                     Ready_i;
    logic [1:0]               Occupancy_o;
    logic                     Sel_Error_o;

    modport slave (
        input  Selector_i, Mux_Data_i, Valid_i, Ready_i,
        output Ready_o, Mux_Output_o, Valid_o, Occupancy_o, Sel_Error_o
    );

    modport master (
        output Selector_i, Mux_Data_i, Valid_i, Ready_i,
        input  Ready_o, Mux_Output_o, Valid_o, Occupancy_o, Sel_Error_o
    );
endinterface

// File: rtl/forward_mux_skid.sv
// forward_mux_skid: N-to-1 operand forwarding mux feeding a 2-entry skid
// buffer (head + skid) with valid/ready handshakes on both sides.
// Ports:
//   clk     - clock, all state on rising edge
//   reset   - synchronous active-high reset
//   Flush_i - drop every buffered operand (branch / exception)
//   bus     - forward_mux_skid_if.slave: selector, concatenated sources,
//             upstream valid/ready, head word, downstream valid/ready,
//             occupancy and sticky selector-error flag
// Optional: define FWD_MUX_SEL_ERROR_EN to enable the sticky Sel_Error_o
// flag; otherwise Sel_Error_o is tied to 0.
module forward_mux_skid #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = $clog2(NInputs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Flush_i,
    forward_mux_skid_if.slave     bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [NBits-1:0]   head_q, head_d;
    logic [NBits-1:0]   skid_q, skid_d;
    logic               ready_q, ready_d;
    logic [NBits-1:0]   sel_word;
    logic               accept, deq;

    // Out-of-range selectors fall through to source 0.
    always_comb begin
        sel_word = bus.Mux_Data_i[0 +: NBits];
        for (int k = 1; k < NInputs; k++)
            if (bus.Selector_i == SelBits'(k))
                sel_word = bus.Mux_Data_i[k*NBits +: NBits];
    end

    assign accept = bus.Valid_i && ready_q;
    assign deq    = (state_q != EMPTY) && bus.Ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (Flush_i) begin
            // Head data is left alone; it is don't-care while invalid.
            state_d = EMPTY;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    head_d  = sel_word;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && deq) begin
                        head_d = sel_word;
                    end else if (accept) begin
                        skid_d  = sel_word;
                        state_d = TWO;
                    end else if (deq) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (deq) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registered ready: open whenever the skid slot will be free.
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.Ready_o      = ready_q;
    assign bus.Valid_o      = (state_q != EMPTY);
    assign bus.Mux_Output_o = head_q;
    assign bus.Occupancy_o  = state_q;

`ifdef FWD_MUX_SEL_ERROR_EN
    logic sel_err_q, sel_err_d;
    logic in_range;

    always_comb begin
        in_range = 1'b0;
        for (int k = 0; k < NInputs; k++)
            if (bus.Selector_i == SelBits'(k))
                in_range = 1'b1;
        // Flush suppresses the accept, so it cannot raise the flag either.
        sel_err_d = sel_err_q | (accept && !Flush_i && !in_range);
    end

    always_ff @(posedge clk) begin
        if (reset) sel_err_q <= 1'b0;
        else       sel_err_q <= sel_err_d;
    end

    assign bus.Sel_Error_o = sel_err_q;
`else
    assign bus.Sel_Error_o = 1'b0;
`endif
endmodule
